// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: default widths,
// next-PC source selection and the target alignment helper.
package pc_pkg;

    localparam int          XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_BYTES_DEFAULT  = 4;

    // Widest address the alignment helper handles; narrower PCs are
    // zero-extended on the way in and truncated on the way out.
    localparam int PC_MAX_W = 64;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_RAS,
        SEL_REDIR,
        SEL_TRAP
    } next_pc_sel_e;

    typedef struct packed {
        logic [PC_MAX_W-1:0] addr;
        logic                misaligned;
    } aligned_pc_t;

    // Clears the low log2(instr_bytes) bits of addr and reports whether any
    // of them were set.
    function automatic aligned_pc_t align_pc(input logic [PC_MAX_W-1:0] addr,
                                             input int unsigned         instr_bytes);
        logic [PC_MAX_W-1:0] mask;
        aligned_pc_t         res;
        mask           = PC_MAX_W'(instr_bytes - 32'd1);
        res.addr       = addr & ~mask;
        res.misaligned = |(addr & mask);
        return res;
    endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Return-address stack: circular buffer with a pointer to the top entry and
// a saturating occupancy count. A push into a full stack silently replaces
// the oldest entry. push and pop together replace the top entry in place.
module return_addr_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign top   = mem_q[ptr_q];

    // Pointer/count update and entry write selection.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (clear) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (push && pop) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
        end else if (push) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q + PTR_W'(1);
            ptr_d  = ptr_q + PTR_W'(1);
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch front end: holds the fetch
// address, offers it over valid/ready and picks the next PC from trap,
// redirect, return-address prediction or the sequential address.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int              INSTR_BYTES  = INSTR_BYTES_DEFAULT,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    input  logic            pc_ready,
    input  logic            pred_call,
    input  logic            pred_ret,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    output logic            misalign_err,
    output logic            ras_underflow
);

    localparam logic [XLEN-1:0] PC_INC = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            misalign_q, misalign_d;
    logic            underflow_q, underflow_d;

    next_pc_sel_e    sel;
    logic            fire;
    logic            flush;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target_aligned;
    aligned_pc_t     target_al;

    logic            ras_push, ras_pop, ras_clear;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty, ras_full;

    assign fire   = pc_valid_q & pc_ready;
    assign flush  = trap_valid | redirect_valid;
    assign pc_seq = pc_q + PC_INC;

    // A flushed instruction must not touch the stack. A pop is only issued
    // when an entry exists; a ret on an empty stack falls back to PC+N.
    assign ras_clear = trap_valid;
    assign ras_push  = fire & pred_call & ~flush;
    assign ras_pop   = fire & pred_ret & ~flush & ~ras_empty;

    return_addr_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .clear     (ras_clear),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Occupancy sanity: a full stack can never also report empty.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(ras_full && ras_empty));
        end
    end

    // Next-PC source selection, target alignment and next-cycle flags.
    always_comb begin
        sel = SEL_HOLD;
        if (trap_valid) begin
            sel = SEL_TRAP;
        end else if (redirect_valid) begin
            sel = SEL_REDIR;
        end else if (fire && pred_ret && !ras_empty) begin
            sel = SEL_RAS;
        end else if (fire) begin
            sel = SEL_SEQ;
        end

        target_raw     = trap_valid ? trap_vec : redirect_pc;
        target_al      = align_pc(PC_MAX_W'(target_raw), INSTR_BYTES);
        target_aligned = XLEN'(target_al.addr);

        pc_d = pc_q;
        unique case (sel)
            SEL_TRAP, SEL_REDIR: pc_d = target_aligned;
            SEL_RAS:             pc_d = ras_top;
            SEL_SEQ:             pc_d = pc_seq;
            default:             pc_d = pc_q;
        endcase

        pc_valid_d  = 1'b1;
        misalign_d  = flush & target_al.misaligned;
        underflow_d = fire & pred_ret & ~flush & ras_empty;
    end

    // PC, valid and one-cycle flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_VECTOR;
            pc_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pc_valid_q  <= pc_valid_d;
            misalign_q  <= misalign_d;
            underflow_q <= underflow_d;
        end
    end

    assign pc_out        = pc_q;
    assign pc_valid      = pc_valid_q;
    assign misalign_err  = misalign_q;
    assign ras_underflow = underflow_q;

endmodule
